// File: rtl/tx_word_serializer_if.sv
// Transmit serializer port bundle: producer-side word offer,
// bit strobe, and serial/status returns.
interface tx_word_serializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  shift_enable;
  logic                  select;
  logic [DATA_WIDTH-1:0] fsm_data;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  data_valid;
  logic                  data_ready;
  logic                  serial_out;
  logic                  word_done;
  logic                  busy;

  modport master (
    output shift_enable,
    output select,
    output fsm_data,
    output fifo_data,
    output data_valid,
    input  data_ready,
    input  serial_out,
    input  word_done,
    input  busy
  );

  modport slave (
    input  shift_enable,
    input  select,
    input  fsm_data,
    input  fifo_data,
    input  data_valid,
    output data_ready,
    output serial_out,
    output word_done,
    output busy
  );
endinterface

// File: rtl/tx_word_serializer.sv
// Mux + holding register + shift register parallel-to-serial stage.
// Define SER_BITSTUFF_EN to insert a 0 after STUFF_LEN consecutive 1s.
module tx_word_serializer #(
  parameter int   DATA_WIDTH = 8,
  parameter bit   SHIFT_MSB  = 1'b0,
  parameter logic IDLE_BIT   = 1'b1,
  parameter int   STUFF_LEN  = 6
) (
  input logic              clk,
  input logic              n_rst,
  tx_word_serializer_if.slave bus
);

  localparam int CW = $clog2(DATA_WIDTH);

  if (DATA_WIDTH < 2 || STUFF_LEN < 1) begin : g_bad_cfg
    $error("tx_word_serializer: bad DATA_WIDTH/STUFF_LEN");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  done_q, done_d;

  logic                  accept;
  logic                  cur_bit;
  logic                  last;
  logic                  finish;
  logic                  take;
  logic                  stuff_now;
  logic [DATA_WIDTH-1:0] shifted;

`ifdef SER_BITSTUFF_EN
  localparam int OW = $clog2(STUFF_LEN + 1);

  logic [OW-1:0] ones_q, ones_d;
  logic          pend_q, pend_d;
  logic          ones_hit;

  assign stuff_now = (int'(ones_q) == STUFF_LEN);
  assign ones_hit  = (int'(ones_q) + 1 == STUFF_LEN);
`else
  assign stuff_now = 1'b0;
`endif

  assign accept  = bus.data_valid & ~hold_full_q;
  assign last    = (cnt_q == CW'(DATA_WIDTH - 1));
  assign cur_bit = SHIFT_MSB ? shift_q[DATA_WIDTH-1]
                             : shift_q[0];
  assign shifted = SHIFT_MSB ? {shift_q[DATA_WIDTH-2:0], 1'b0}
                             : {1'b0, shift_q[DATA_WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    finish      = 1'b0;
    take        = 1'b0;
`ifdef SER_BITSTUFF_EN
    ones_d      = ones_q;
    pend_d      = pend_q;
`endif

    if (accept) begin
      hold_d      = bus.select ? bus.fsm_data
                               : bus.fifo_data;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
`ifdef SER_BITSTUFF_EN
        ones_d = '0;
        pend_d = 1'b0;
`endif
        if (hold_full_q) begin
          take    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.shift_enable) begin
`ifdef SER_BITSTUFF_EN
          if (stuff_now) begin
            // stuffed bit: no data consumed
            ones_d = '0;
            if (pend_q) begin
              pend_d = 1'b0;
              finish = 1'b1;
            end
          end else begin
            ones_d = cur_bit ? ones_q + OW'(1) : '0;
            if (last) begin
              if (cur_bit && ones_hit) pend_d = 1'b1;
              else                     finish = 1'b1;
            end else begin
              shift_d = shifted;
              cnt_d   = cnt_q + CW'(1);
            end
          end
`else
          if (last) begin
            finish = 1'b1;
          end else begin
            shift_d = shifted;
            cnt_d   = cnt_q + CW'(1);
          end
`endif
        end
      end
      default: ;
    endcase

    if (finish) begin
      done_d = 1'b1;
      if (hold_full_q) begin
        take = 1'b1;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end

    // accept and take are exclusive: accept needs hold empty
    if (take) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
    end
  end

`ifdef SER_BITSTUFF_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ones_q <= '0;
      pend_q <= 1'b0;
    end else begin
      ones_q <= ones_d;
      pend_q <= pend_d;
    end
  end
`endif

  assign bus.data_ready = ~hold_full_q;
  assign bus.busy       = (state_q == SHIFT) | hold_full_q;
  assign bus.word_done  = done_q;
  assign bus.serial_out = (state_q == SHIFT)
                        ? (stuff_now ? 1'b0 : cur_bit)
                        : IDLE_BIT;

endmodule

// File: tb/tb_tx_word_serializer.sv
// Directed bench for tx_word_serializer (LSB-first and
// MSB-first instances sharing clock and reset).
module tb_tx_word_serializer;

  logic clk = 1'b0;
  logic n_rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  tx_word_serializer_if #(.DATA_WIDTH(8)) b ();
  tx_word_serializer_if #(.DATA_WIDTH(8)) m ();

  tx_word_serializer #(
    .DATA_WIDTH(8)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (b.slave)
  );

  tx_word_serializer #(
    .DATA_WIDTH(8),
    .SHIFT_MSB (1'b1)
  ) dut_msb (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (m.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    b.shift_enable = 0; b.select = 0; b.data_valid = 0;
    b.fsm_data = '0; b.fifo_data = '0;
    m.shift_enable = 0; m.select = 0; m.data_valid = 0;
    m.fsm_data = '0; m.fifo_data = '0;
    n_rst = 0;
    tick(); tick();
    checks++;
    if ({b.serial_out, b.data_ready, b.busy, b.word_done}
        !== 4'b1100) begin
      errors++;
      $display("FAIL reset_lsb got=%b want=1100",
        {b.serial_out, b.data_ready, b.busy, b.word_done});
    end
    checks++;
    if ({m.serial_out, m.data_ready, m.busy, m.word_done}
        !== 4'b1100) begin
      errors++;
      $display("FAIL reset_msb got=%b want=1100",
        {m.serial_out, m.data_ready, m.busy, m.word_done});
    end
    n_rst = 1;
    tick();
  endtask

  task automatic test_single();
    logic [7:0] exp;
    int dn;
    exp = 8'hA5;
    dn  = 0;
    b.fifo_data = 8'hA5; b.fsm_data = 8'h3C;
    b.select = 0; b.data_valid = 1;
    tick();
    b.data_valid = 0;
    checks++;
    if ({b.data_ready, b.busy, b.serial_out} !== 3'b011) begin
      errors++;
      $display("FAIL single_held got=%b want=011",
        {b.data_ready, b.busy, b.serial_out});
    end
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (b.serial_out !== exp[i]) begin
        errors++;
        $display("FAIL single_bit%0d got=%b want=%b",
          i, b.serial_out, exp[i]);
      end
      b.shift_enable = 1;
      tick();
      b.shift_enable = 0;
      if (b.word_done) dn++;
      checks++;
      if (b.word_done !== (i == 7)) begin
        errors++;
        $display("FAIL single_done%0d got=%b want=%b",
          i, b.word_done, (i == 7));
      end
      tick();
      if (b.word_done) dn++;
    end
    checks++;
    if (dn != 1) begin
      errors++;
      $display("FAIL single_pulses got=%0d want=1", dn);
    end
    checks++;
    if ({b.serial_out, b.data_ready, b.busy} !== 3'b110) begin
      errors++;
      $display("FAIL single_idle got=%b want=110",
        {b.serial_out, b.data_ready, b.busy});
    end
  endtask

  task automatic test_mux_msb();
    logic [7:0] exp;
    exp = 8'h81;
    m.fsm_data = 8'h81; m.fifo_data = 8'h00;
    m.select = 1; m.data_valid = 1;
    tick();
    m.data_valid = 0;
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (m.serial_out !== exp[7-i]) begin
        errors++;
        $display("FAIL msb_bit%0d got=%b want=%b",
          i, m.serial_out, exp[7-i]);
      end
      m.shift_enable = 1;
      tick();
      m.shift_enable = 0;
      checks++;
      if (m.word_done !== (i == 7)) begin
        errors++;
        $display("FAIL msb_done%0d got=%b want=%b",
          i, m.word_done, (i == 7));
      end
    end
    tick();
    checks++;
    if ({m.serial_out, m.busy} !== 2'b10) begin
      errors++;
      $display("FAIL msb_idle got=%b want=10",
        {m.serial_out, m.busy});
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    int dn;
    exp = 16'b1111000000001111;
    dn  = 0;
    b.select = 0;
    b.fifo_data = 8'h0F; b.data_valid = 1;
    tick();
    b.data_valid = 0;
    tick();
    b.fifo_data = 8'hF0; b.data_valid = 1;
    tick();
    b.data_valid = 0;
    checks++;
    if ({b.data_ready, b.busy} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_hold got=%b want=01",
        {b.data_ready, b.busy});
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (b.serial_out !== exp[15-i]) begin
        errors++;
        $display("FAIL b2b_bit%0d got=%b want=%b",
          i, b.serial_out, exp[15-i]);
      end
      b.shift_enable = 1;
      tick();
      b.shift_enable = 0;
      if (b.word_done) dn++;
      if (i == 7) begin
        checks++;
        if ({b.word_done, b.data_ready, b.busy} !== 3'b111) begin
          errors++;
          $display("FAIL b2b_seam got=%b want=111",
            {b.word_done, b.data_ready, b.busy});
        end
      end
    end
    checks++;
    if (dn != 2) begin
      errors++;
      $display("FAIL b2b_pulses got=%0d want=2", dn);
    end
    tick();
    checks++;
    if ({b.serial_out, b.busy, b.word_done} !== 3'b100) begin
      errors++;
      $display("FAIL b2b_idle got=%b want=100",
        {b.serial_out, b.busy, b.word_done});
    end
  endtask

  task automatic test_stuffing();
`ifdef SER_BITSTUFF_EN
    logic [8:0] exp;
    int n;
    exp = 9'b111111011;
    n   = 9;
`else
    logic [8:0] exp;
    int n;
    exp = 9'b011111111;
    n   = 8;
`endif
    b.select = 0;
    b.fifo_data = 8'hFF; b.data_valid = 1;
    tick();
    b.data_valid = 0;
    tick();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (b.serial_out !== exp[n-1-i]) begin
        errors++;
        $display("FAIL stuff_bit%0d got=%b want=%b",
          i, b.serial_out, exp[n-1-i]);
      end
      b.shift_enable = 1;
      tick();
      b.shift_enable = 0;
      checks++;
      if (b.word_done !== (i == n - 1)) begin
        errors++;
        $display("FAIL stuff_done%0d got=%b want=%b",
          i, b.word_done, (i == n - 1));
      end
    end
    tick();
    checks++;
    if ({b.serial_out, b.busy} !== 2'b10) begin
      errors++;
      $display("FAIL stuff_idle got=%b want=10",
        {b.serial_out, b.busy});
    end
  endtask

  task automatic test_reset_mid_word();
    b.select = 0;
    b.fifo_data = 8'h3C; b.data_valid = 1;
    tick();
    b.data_valid = 0;
    tick();
    b.shift_enable = 1;
    tick(); tick();
    b.shift_enable = 0;
    checks++;
    if ({b.serial_out, b.busy} !== 2'b11) begin
      errors++;
      $display("FAIL mid_pre got=%b want=11",
        {b.serial_out, b.busy});
    end
    #2;
    n_rst = 0;
    #1;
    checks++;
    if ({b.serial_out, b.data_ready, b.busy, b.word_done}
        !== 4'b1100) begin
      errors++;
      $display("FAIL mid_reset got=%b want=1100",
        {b.serial_out, b.data_ready, b.busy, b.word_done});
    end
    tick();
    n_rst = 1;
    tick(); tick();
    checks++;
    if ({b.serial_out, b.data_ready, b.busy} !== 3'b110) begin
      errors++;
      $display("FAIL mid_after got=%b want=110",
        {b.serial_out, b.data_ready, b.busy});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_mux_msb();
    test_back_to_back();
    test_stuffing();
    test_reset_mid_word();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_word_serializer.md
# tx_word_serializer

Parametrised parallel-to-serial transmit stage for the transmitter datapath. Selects a word from either the FIFO or the protocol FSM, holds it in a one-entry holding register, and shifts it out one bit per `shift_enable` strobe. Back-to-back words are sent with no idle bit between them. Generalises the fixed 8-bit mux-plus-shift-register stage with configurable width, bit order, idle level, a valid/ready load handshake, bit counting and word-done signalling, plus optional bit stuffing.

## Interface
Parameters:
- `DATA_WIDTH`, 8, word width in bits (≥2)
- `SHIFT_MSB`, 0, 1 = MSB first, 0 = LSB first
- `IDLE_BIT`, 1'b1, `serial_out` level when no word is in flight
- `STUFF_LEN`, 6, run of consecutive 1s that forces a stuffed 0 (used only with `SER_BITSTUFF_EN`)

Ports:
- `clk`  in  1  system clock, rising edge
- `n_rst`  in  1  asynchronous, active-low reset
- `shift_enable`  in  1  bit-time strobe; advances the output by one bit
- `select`  in  1  source select: 0 = `fifo_data`, 1 = `fsm_data`
- `fsm_data`  in  DATA_WIDTH  word from the transmit FSM
- `fifo_data`  in  DATA_WIDTH  word from the transmit FIFO
- `data_valid`  in  1  producer offers the selected word
- `data_ready`  out  1  holding register empty; the word is accepted when valid & ready
- `serial_out`  out  1  current transmit bit
- `word_done`  out  1  one-cycle pulse when the last bit of a word is consumed
- `busy`  out  1  word in the shift register or in the holding register

## Operation
- Reset values: `data_ready`=1, `serial_out`=`IDLE_BIT`, `word_done`=0, `busy`=0; state IDLE, holding and shift registers cleared, bit counter 0.
- Accept: on a clock edge with `data_valid & data_ready`, the muxed word (`select` sampled that cycle) is latched into the holding register. `data_ready` = !hold_full, decoded from registered state.
- States:
  - IDLE: `serial_out`=`IDLE_BIT`. If hold_full, go to SHIFT at the next edge: load the shift register, clear hold_full, bit counter=0. `shift_enable` is ignored in IDLE.
  - SHIFT: `serial_out` = shift register bit 0 (LSB first) or bit DATA_WIDTH-1 (MSB first). Each `shift_enable` shifts by one and increments the counter.
- Last bit (counter = DATA_WIDTH-1 and `shift_enable`): pulse `word_done`.
  - If hold_full in that same cycle: reload from hold, stay in SHIFT, counter=0. This gives a seamless next word.
  - Otherwise: go to IDLE.
- Simultaneous accept and transfer out of hold in one cycle: the new word is not accepted, because `data_ready` was 0. No overwrite is possible.
- Counter width is $clog2(DATA_WIDTH); no wrap-around beyond DATA_WIDTH-1.
- `busy` = (state==SHIFT) | hold_full.

## Timing
- Accept to first bit on `serial_out`: 2 edges (latch into hold, then load into shift).
- Each bit is held until the next `shift_enable`. A word occupies exactly DATA_WIDTH strobes (more with stuffing).
- `word_done` is asserted for the cycle after the final strobe edge. It is registered.
- Asynchronous reset mid-word: outputs return to their reset values immediately and the partial word is discarded.

## Configuration
- `SER_BITSTUFF_EN` defined:
  - A ones counter tracks consecutive 1s consumed by `shift_enable` in SHIFT.
  - When it reaches `STUFF_LEN`, the next bit time outputs 0. The strobe that consumes it does not shift or advance the bit counter, and the ones counter clears.
  - Any consumed 0 clears the ones counter.
  - The ones counter is preserved across seamless word boundaries and cleared in IDLE.
  - `word_done` is delayed until any pending stuffed bit after the last data bit has been consumed.
- Undefined: no stuffing logic; the ones counter is absent; `STUFF_LEN` is ignored.

## Test plan
- Reset: assert `n_rst`=0 mid-word → `serial_out`=1, `data_ready`=1, `busy`=0, `word_done`=0.
- Single word, defaults: `fifo_data`=8'hA5, `select`=0, one valid cycle, then 8 strobes → `serial_out` sequence 1,0,1,0,0,1,0,1. `word_done` pulses once. Return to IDLE with output 1.
- Source mux, MSB first: `SHIFT_MSB`=1, `select`=1, `fsm_data`=8'h81, `fifo_data`=8'h00 → sequence 1,0,0,0,0,0,0,1.
- Back-to-back: send 8'h0F, then offer 8'hF0 while the first shifts → 16 consecutive strobes yield 1111000000001111 with no idle bit. `word_done` pulses twice. `data_ready`=0 while hold is full.
- Stuffing (macro on): send 8'hFF → output 1,1,1,1,1,1,0,1,1 over 9 strobes; `word_done` follows the 9th strobe.
- Stuffing (macro off): send 8'hFF → eight 1s over 8 strobes.
